// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg -- shared types and default sizing for the scoreboarded
// register file (regfile_sb and its read-port slice).
package regfile_sb_pkg;

  // Two-phase life cycle: sweep the array to zero, then serve traffic.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUM      = 32;
  localparam int DEF_NREAD    = 2;
  localparam int DEF_ZERO_REG = 1;

endpackage

// File: rtl/regfile_sb_rdport.sv
// regfile_sb_rdport -- one combinational read port of regfile_sb: array mux,
// hard-wired zero register and optional write-to-read forwarding.
// Build option: define REGFILE_SB_BYPASS_EN to forward the in-flight
// writeback (data and cleared pending flag) to a matching read address.
module regfile_sb_rdport
  import regfile_sb_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int NUM      = DEF_NUM,
  parameter  int ZERO_REG = DEF_ZERO_REG,
  localparam int AW       = $clog2(NUM)
) (
  input  logic             run,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] mem [NUM],
  input  logic [NUM-1:0]   pending,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_busy
);

  logic is_zero;
  assign is_zero = (ZERO_REG != 0) && (rd_addr == '0);

  // Select array entry and its pending flag; blank everything while sweeping.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs -- no latch.
    rd_data = '0;
    rd_busy = 1'b0;
    if (run && !is_zero) begin
      rd_data = mem[rd_addr];
      rd_busy = pending[rd_addr];
`ifdef REGFILE_SB_BYPASS_EN
      if (wr_en && (rd_addr == wr_addr)) begin
        rd_data = wr_data;
        rd_busy = 1'b0;
      end
`endif
    end
  end

`ifndef REGFILE_SB_BYPASS_EN
  // Writeback inputs only feed the forwarding path.
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data};
`endif

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- register file with per-entry pending (scoreboard) bits.
// After reset it zeroes every entry, one per clock, then raises ready.
// Build option: define REGFILE_SB_BYPASS_EN to forward writeback data to
// same-cycle reads (see regfile_sb_rdport).
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int NUM      = DEF_NUM,
  parameter  int NREAD    = DEF_NREAD,
  parameter  int ZERO_REG = DEF_ZERO_REG,
  localparam int AW       = $clog2(NUM)
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   ready,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_busy
);

  state_e           state;
  logic [AW-1:0]    clr_ptr;
  logic [NUM-1:0]   pending;
  logic [NUM-1:0]   pending_nxt;
  logic [WIDTH-1:0] mem [NUM];

  logic             run;
  logic             wr_ok;
  logic             iss_ok;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  assign run    = (state == ST_RUN);
  assign ready  = run;
  assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
  assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

  // Sweep pointer walks 0..NUM-1 once, then the block switches to RUN.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset) begin
      state   <= ST_INIT;
      clr_ptr <= '0;
    end else if (state == ST_INIT) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == AW'(NUM - 1)) state <= ST_RUN;
    end
  end

  // Writeback clears the pending bit; a same-cycle issue re-sets it and wins.
  always_comb begin
    pending_nxt = pending;
    if (wr_en)  pending_nxt[wr_addr]  = 1'b0;
    if (iss_ok) pending_nxt[iss_addr] = 1'b1;
  end

  // Scoreboard only moves in RUN; reset empties it immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   pending <= '0;
    else if (run) pending <= pending_nxt;
  end

  // Single array write port shared by the zeroing sweep and writeback.
  assign mem_we    = reset && (run ? wr_ok : 1'b1);
  assign mem_waddr = run ? wr_addr : clr_ptr;
  assign mem_wdata = run ? wr_data : '0;

  // Array storage.
  always_ff @(posedge clock) begin
    // NOTE: no reset on the array -- contents are cleared by the INIT sweep,
    // which keeps this a plain RAM-style write.
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_sb_rdport #(
      .WIDTH    (WIDTH),
      .NUM      (NUM),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .run     (run),
      .rd_addr (rd_addr[k*AW +: AW]),
      .mem     (mem),
      .pending (pending),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[k*WIDTH +: WIDTH]),
      .rd_busy (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- directed scenarios plus random traffic for regfile_sb,
// compared each cycle against an array/counter reference model.
module tb_regfile_sb;

  localparam int WIDTH = 32;
  localparam int NUM   = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                   clock;
  logic                   reset;
  logic                   ready;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic                   iss_en;
  logic [AW-1:0]          iss_addr;
  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*WIDTH-1:0] rd_data;
  logic [NREAD-1:0]       rd_busy;

  regfile_sb #(
    .WIDTH    (WIDTH),
    .NUM      (NUM),
    .NREAD    (NREAD),
    .ZERO_REG (1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ready    (ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    else passed++;
  endtask

  // Reference model: register values, pending flags, clocks since reset.
  logic [WIDTH-1:0] m_reg  [NUM];
  bit               m_pend [NUM];
  int               m_cycles  = 0;
  bit               in_reset  = 1'b1;

  function automatic bit exp_ready();
    return !in_reset && (m_cycles >= NUM);
  endfunction

  function automatic logic [WIDTH-1:0] exp_data(input int a);
    if (!exp_ready() || a == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_en && a == int'(wr_addr)) return wr_data;
`endif
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (!exp_ready() || a == 0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_en && a == int'(wr_addr)) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  task automatic compare_outputs();
    check("ready", {63'd0, ready}, {63'd0, exp_ready()});
    for (int k = 0; k < NREAD; k++) begin
      int a;
      a = int'(rd_addr[k*AW +: AW]);
      check($sformatf("data_p%0d_x%0d", k, a), {32'd0, rd_data[k*WIDTH +: WIDTH]}, {32'd0, exp_data(a)});
      check($sformatf("busy_p%0d_x%0d", k, a), {63'd0, rd_busy[k]}, {63'd0, exp_busy(a)});
    end
  endtask

  // Apply one cycle of inputs (called just after a negedge) and compare.
  task automatic cycle_begin(input bit we, input int wa, input logic [WIDTH-1:0] wd,
                             input bit ie, input int ia, input int r0, input int r1);
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    iss_en   = ie;
    iss_addr = AW'(ia);
    rd_addr  = {AW'(r1), AW'(r0)};
    #1 compare_outputs();
  endtask

  // Advance the model across the posedge, then park at the next negedge.
  task automatic cycle_end();
    @(posedge clock);
    if (m_cycles < NUM) begin
      m_cycles++;
      if (m_cycles == NUM)
        for (int i = 0; i < NUM; i++) m_reg[i] = '0;
    end else begin
      if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
      if (wr_en) m_pend[wr_addr] = 1'b0;
      if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic nop_cycle(input int r0, input int r1);
    cycle_begin(0, 0, '0, 0, 0, r0, r1);
    cycle_end();
  endtask

  task automatic random_cycle();
    int wa, ia, r0, r1;
    wa = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, NUM - 1);
    ia = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 7);
    r0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 7);
    r1 = ($urandom_range(0, 3) == 0) ? r0 : $urandom_range(0, NUM - 1);
    cycle_begin($urandom_range(0, 1), wa, $urandom(), $urandom_range(0, 2) == 0, ia, r0, r1);
    cycle_end();
  endtask

  // Pulse reset asynchronously mid-cycle, checking that it bites at once.
  task automatic do_reset(input int r0, input int r1);
    cycle_begin(0, 0, '0, 0, 0, r0, r1);
    #1 reset = 1'b0;
    in_reset = 1'b1;
    m_cycles = 0;
    for (int i = 0; i < NUM; i++) m_pend[i] = 1'b0;
    #1;
    check("rst_ready_drop", {63'd0, ready}, 64'd0);
    check("rst_busy_clear", {62'd0, rd_busy}, 64'd0);
    compare_outputs();
    @(negedge clock);
    reset    = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
    for (int i = 0; i < NUM; i++) m_pend[i] = 1'b0;

    repeat (2) @(negedge clock);
    #1 check("por_ready", {63'd0, ready}, 64'd0);
    @(negedge clock);
    reset    = 1'b1;
    in_reset = 1'b0;

    // Partial sweep with junk traffic, then reset at clr_ptr = 10.
    for (int i = 0; i < 10; i++) random_cycle();
    do_reset(3, 17);

    // Full sweep: ready must be low for 32 clocks, then high.
    for (int i = 0; i < NUM; i++) begin
      cycle_begin($urandom_range(0, 1), $urandom_range(1, 31), $urandom(), 1'b1,
                  $urandom_range(1, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      check("init_ready_low", {63'd0, ready}, 64'd0);
      check("init_data_zero", rd_data, 64'd0);
      check("init_busy_zero", {62'd0, rd_busy}, 64'd0);
      cycle_end();
    end
    cycle_begin(0, 0, '0, 0, 0, 1, 2);
    check("ready_at_clock_32", {63'd0, ready}, 64'd1);
    cycle_end();

    // Basic write / dual-port read / zero register.
    cycle_begin(1, 5, 32'hDEADBEEF, 0, 0, 1, 2);
    cycle_end();
    cycle_begin(0, 0, '0, 0, 0, 5, 5);
    check("x5_port0", {32'd0, rd_data[31:0]},  64'hDEADBEEF);
    check("x5_port1", {32'd0, rd_data[63:32]}, 64'hDEADBEEF);
    cycle_end();
    cycle_begin(1, 0, 32'h1234_5678, 1, 0, 0, 5);
    cycle_end();
    cycle_begin(0, 0, '0, 0, 0, 0, 0);
    check("x0_still_zero", rd_data, 64'd0);
    check("x0_never_busy", {62'd0, rd_busy}, 64'd0);
    cycle_end();

    // Scoreboard: issue, writeback, same-cycle issue+writeback.
    cycle_begin(0, 0, '0, 1, 7, 7, 0);
    cycle_end();
    cycle_begin(0, 0, '0, 0, 0, 7, 0);
    check("x7_busy_after_issue", {63'd0, rd_busy[0]}, 64'd1);
    cycle_end();
    cycle_begin(1, 7, 32'h12, 0, 0, 7, 0);
    cycle_end();
    cycle_begin(0, 0, '0, 0, 0, 7, 0);
    check("x7_busy_after_wb", {63'd0, rd_busy[0]}, 64'd0);
    check("x7_data_after_wb", {32'd0, rd_data[31:0]}, 64'h12);
    cycle_end();
    cycle_begin(1, 9, 32'h99, 1, 9, 0, 9);
    cycle_end();
    cycle_begin(0, 0, '0, 0, 0, 0, 9);
    check("x9_set_wins_busy", {63'd0, rd_busy[1]}, 64'd1);
    check("x9_set_wins_data", {32'd0, rd_data[63:32]}, 64'h99);
    cycle_end();

    // Read during write of the same register.
    cycle_begin(1, 3, 32'h11, 0, 0, 0, 0);
    cycle_end();
    cycle_begin(1, 3, 32'hA5, 0, 0, 3, 0);
`ifdef REGFILE_SB_BYPASS_EN
    check("x3_bypass_data", {32'd0, rd_data[31:0]}, 64'hA5);
    check("x3_bypass_busy", {63'd0, rd_busy[0]}, 64'd0);
`else
    check("x3_old_data", {32'd0, rd_data[31:0]}, 64'h11);
`endif
    cycle_end();
    cycle_begin(0, 0, '0, 0, 0, 3, 0);
    check("x3_new_data", {32'd0, rd_data[31:0]}, 64'hA5);
    cycle_end();

    // Random traffic.
    for (int i = 0; i < 500; i++) random_cycle();

    // Reset in RUN with pending bits set and x5 written.
    cycle_begin(1, 5, 32'hCAFEF00D, 1, 12, 0, 0);
    cycle_end();
    cycle_begin(0, 0, '0, 1, 13, 12, 5);
    check("pre_rst_x12_busy", {63'd0, rd_busy[0]}, 64'd1);
    cycle_end();
    do_reset(12, 13);
    for (int i = 0; i < NUM; i++) nop_cycle(5, 12);
    cycle_begin(0, 0, '0, 0, 0, 5, 12);
    check("post_rst_ready", {63'd0, ready}, 64'd1);
    check("post_rst_x5_zero", {32'd0, rd_data[31:0]}, 64'd0);
    check("post_rst_x12_idle", {63'd0, rd_busy[1]}, 64'd0);
    cycle_end();

    for (int i = 0; i < 100; i++) random_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 32, sets the data bits per register.
REQ-002 Parameter NUM, default 32, sets the register count, a power of two >= 2; AW = $clog2(NUM).
REQ-003 Parameter NREAD, default 2, sets the number of combinational read ports, range 1..4.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 reads 0, ignores writes and is never busy.
REQ-005 clock  in  1  single clock; all state updates on posedge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 ready  out  1  high once the clear sequence has finished.
REQ-008 wr_en  in  1  writeback strobe.
REQ-009 wr_addr  in  AW  writeback register index.
REQ-010 wr_data  in  WIDTH  writeback data.
REQ-011 iss_en  in  1  issue strobe; marks iss_addr pending.
REQ-012 iss_addr  in  AW  destination index of the issuing instruction.
REQ-013 rd_addr  in  NREAD*AW  packed read indices; port k occupies bits [k*AW +: AW].
REQ-014 rd_data  out  NREAD*WIDTH  packed read data; port k occupies bits [k*WIDTH +: WIDTH].
REQ-015 rd_busy  out  NREAD  per-port pending flag for rd_addr.

Function
REQ-016 The block SHALL implement a two-state FSM: INIT and RUN.
REQ-017 In INIT, each clock SHALL write 0 to entry clr_ptr and increment clr_ptr; after the write to NUM-1 the FSM SHALL enter RUN.
REQ-018 ready SHALL be 0 in INIT and 1 in RUN; the first ready=1 cycle is exactly NUM clocks after reset deassertion.
REQ-019 In INIT, wr_en and iss_en SHALL be ignored, all rd_data SHALL be 0 and all rd_busy SHALL be 0.
REQ-020 In RUN, wr_en=1 SHALL write wr_data to entry wr_addr at posedge, except address 0 when ZERO_REG=1.
REQ-021 In RUN, wr_en=1 SHALL clear pending[wr_addr] at the same posedge.
REQ-022 In RUN, iss_en=1 SHALL set pending[iss_addr], except address 0 when ZERO_REG=1.
REQ-023 If wr_en and iss_en target the same address in one cycle, the set SHALL win: the data is written and pending ends 1.
REQ-024 Reads SHALL be combinational: rd_data[k] = reg[rd_addr[k]] and rd_busy[k] = pending[rd_addr[k]].
REQ-025 When ZERO_REG=1, rd_addr[k]=0 SHALL give rd_data 0 and rd_busy 0.
REQ-026 Any number of ports SHALL be allowed to read the same address simultaneously.

Reset
REQ-027 reset low SHALL immediately force the FSM to INIT, clr_ptr to 0, all pending bits to 0 and ready to 0, including in the middle of INIT or RUN.
REQ-028 Register contents SHALL NOT be reset asynchronously; they are zeroed only by the INIT sweep.

Configuration
REQ-029 Macro REGFILE_SB_BYPASS_EN compiles in write-to-read forwarding.
REQ-030 With REGFILE_SB_BYPASS_EN, in RUN, when wr_en=1 and rd_addr[k]==wr_addr (and not address 0 when ZERO_REG=1), port k SHALL return wr_data and rd_busy[k]=0 in the same cycle.
REQ-031 Without REGFILE_SB_BYPASS_EN, reads SHALL return pre-write contents and the pre-write pending value; the new value is visible one cycle later.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (INIT, RUN) and the default parameter constants.
REQ-033 A sub-module regfile_sb_rdport SHALL implement one read port (mux, zero-register, bypass), instantiated NREAD times by a generate loop.

Verification
REQ-034 Release reset with NUM=32: ready rises on clock 32; every port reads 0 with busy=0 throughout INIT.
REQ-035 In RUN, write 0xDEADBEEF to x5, then read x5 on ports 0 and 1 -> both return 0xDEADBEEF; a write to x0 -> x0 still reads 0.
REQ-036 Issue x7, then read -> rd_busy=1; write x7=0x12 -> busy=0 from the next cycle; same-cycle issue and write of x9 -> busy=1 and data updated.
REQ-037 With the bypass macro defined, write x3=0xA5 while port 0 reads x3 -> 0xA5 and busy=0 in the same cycle; without the macro -> old value, then 0xA5 next cycle.
REQ-038 Assert reset at clr_ptr=10 during INIT and again in RUN with pending bits set -> ready drops immediately, pending clears, a full 32-cycle sweep restarts and a previously written x5 reads 0 afterwards.
